// File: rtl/fft_frame_src.sv
// fft_frame_src
//   Frame source for the N-point FFT datapath. Emits frames of N_POINTS complex
//   samples with sop/eop/valid framing. It supports selectable test patterns,
//   a frame count (0 = continuous) and a programmable inter-frame gap.
//
// Ports
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   start             pulse: latch configuration and begin (only honoured in IDLE)
//   stop              halt request, honoured at the next frame boundary (or in GAP)
//   mode              pattern: 0 ramp down, 1 ramp up, 2 const, 3 impulse,
//                     4 nyquist, 5 PRBS, 6/7 zero
//   num_frames        frames to send, 0 = until stop
//   gap_cycles        idle cycles between eop and next sop
//   amp, step         amplitude / start value and ramp increment
//   valid_out, sop_out, eop_out, x_re, x_im   registered sample stream
//   frame_idx         0-based index of the frame being sent
//   busy              high while running or in a gap
//   done              one-cycle pulse at the end of a sequence

module fft_frame_src #(
  parameter int          N_POINTS  = 256,
  parameter int          LOG2N     = 8,
  parameter int          DW        = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [2:0]    mode,
  input  logic [15:0]   num_frames,
  input  logic [15:0]   gap_cycles,
  input  logic [DW-1:0] amp,
  input  logic [DW-1:0] step,
  output logic          valid_out,
  output logic          sop_out,
  output logic          eop_out,
  output logic [DW-1:0] x_re,
  output logic [DW-1:0] x_im,
  output logic [15:0]   frame_idx,
  output logic          busy,
  output logic          done
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  state_t           r_state;
  state_t           w_stateNext;

  // Latched configuration
  logic [2:0]       r_mode;
  logic [15:0]      r_numFrames;
  logic [15:0]      r_gapCycles;
  logic [DW-1:0]    r_amp;
  logic [DW-1:0]    r_step;

  // Sequencing state; r_idx and r_acc describe the sample currently on the outputs
  logic [LOG2N-1:0] r_idx;
  logic [DW-1:0]    r_acc;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_gapCnt;
  logic             r_stopSeen;

  // Registered outputs
  logic             r_valid;
  logic             r_sop;
  logic             r_eop;
  logic [DW-1:0]    r_re;
  logic [DW-1:0]    r_im;
  logic [15:0]      r_frameIdx;
  logic             r_busy;
  logic             r_done;

  // Decisions from the next-state logic
  logic             w_accept;
  logic             w_emit;
  logic             w_newFrame;
  logic             w_stopNow;
  logic             w_lastFrame;

  // Values for the next output sample
  logic [2:0]       w_mode;
  logic [DW-1:0]    w_amp;
  logic [DW-1:0]    w_step;
  logic [LOG2N-1:0] w_nIdx;
  logic [DW-1:0]    w_accNext;
  logic [15:0]      w_lfsrCur;
  logic [DW-1:0]    w_prbs;
  logic [DW-1:0]    w_reNext;
  logic [DW-1:0]    w_imNext;
  logic             w_eopNext;
  logic             w_busyNext;
  logic             w_doneNext;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right
  function automatic logic [15:0] lfsrAdvance(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_stateNext;
  end

  // A stop seen this cycle counts the same as one seen earlier in the frame.
  assign w_stopNow   = stop | r_stopSeen;
  // frame_idx is the frame now ending, so frames sent after this eop is frame_idx+1.
  assign w_lastFrame = (r_numFrames != 16'd0) && ((r_frameIdx + 16'd1) == r_numFrames);

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    w_newFrame  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_stateNext = S_RUN;
          w_accept    = 1'b1;
          w_emit      = 1'b1;
          w_newFrame  = 1'b1;
        end
      end
      S_RUN: begin
        if (r_idx != LAST) begin
          w_emit = 1'b1;
        end else if (w_stopNow || w_lastFrame) begin
          w_stateNext = S_DONE;
        end else if (r_gapCycles == 16'd0) begin
          w_emit     = 1'b1;
          w_newFrame = 1'b1;
        end else begin
          w_stateNext = S_GAP;
        end
      end
      S_GAP: begin
        if (w_stopNow) begin
          w_stateNext = S_DONE;
        end else if (r_gapCnt == 16'd0) begin
          w_stateNext = S_RUN;
          w_emit      = 1'b1;
          w_newFrame  = 1'b1;
        end
      end
      S_DONE: w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // On the accepting edge the configuration registers are not yet loaded,
  // so the first sample is built straight from the inputs.
  always_comb begin
    w_mode    = w_accept ? mode : r_mode;
    w_amp     = w_accept ? amp  : r_amp;
    w_step    = w_accept ? step : r_step;
    w_lfsrCur = w_accept ? LFSR_SEED : r_lfsr;
    w_prbs    = DW'(w_lfsrCur);
    w_nIdx    = w_newFrame ? '0 : r_idx + LOG2N'(1);

    // Ramp accumulator reloads at each sop instead of computing n*step.
    if (w_newFrame)          w_accNext = w_amp;
    else if (w_mode == 3'd0) w_accNext = r_acc - w_step;
    else                     w_accNext = r_acc + w_step;

    w_reNext = '0;
    w_imNext = '0;
    if (w_emit) begin
      unique case (w_mode)
        3'd0, 3'd1: begin
          w_reNext = w_accNext;
          w_imNext = w_accNext;
        end
        3'd2: w_reNext = w_amp;
        3'd3: w_reNext = (w_nIdx == '0) ? w_amp : '0;
        3'd4: w_reNext = w_nIdx[0] ? ('0 - w_amp) : w_amp;
        3'd5: begin
          w_reNext = w_prbs;
          w_imNext = ~w_prbs;
        end
        default: begin
          w_reNext = '0;
          w_imNext = '0;
        end
      endcase
    end

    w_eopNext  = w_emit && (w_nIdx == LAST);
    w_busyNext = (w_stateNext == S_RUN) || (w_stateNext == S_GAP);
    w_doneNext = (w_stateNext == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= '0;
      r_numFrames <= '0;
      r_gapCycles <= '0;
      r_amp       <= '0;
      r_step      <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_gapCnt    <= '0;
      r_stopSeen  <= 1'b0;
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_re        <= '0;
      r_im        <= '0;
      r_frameIdx  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode      <= mode;
        r_numFrames <= num_frames;
        r_gapCycles <= gap_cycles;
        r_amp       <= amp;
        r_step      <= step;
      end

      if (w_emit) begin
        r_idx  <= w_nIdx;
        r_acc  <= w_accNext;
        r_lfsr <= lfsrAdvance(w_lfsrCur);
      end

      if (w_emit && w_newFrame)
        r_frameIdx <= w_accept ? 16'd0 : r_frameIdx + 16'd1;

      if (w_stateNext == S_IDLE)
        r_stopSeen <= 1'b0;
      else if (((r_state == S_RUN) || (r_state == S_GAP)) && stop)
        r_stopSeen <= 1'b1;

      // Counter loaded with gap-1 so the GAP state lasts exactly gap_cycles cycles.
      if ((r_state == S_RUN) && (w_stateNext == S_GAP))
        r_gapCnt <= r_gapCycles - 16'd1;
      else if (r_state == S_GAP)
        r_gapCnt <= r_gapCnt - 16'd1;

      r_valid <= w_emit;
      r_sop   <= w_emit && w_newFrame;
      r_eop   <= w_eopNext;
      r_re    <= w_reNext;
      r_im    <= w_imNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
    end
  end

  assign valid_out = r_valid;
  assign sop_out   = r_sop;
  assign eop_out   = r_eop;
  assign x_re      = r_re;
  assign x_im      = r_im;
  assign frame_idx = r_frameIdx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_fft_frame_src.sv
// Testbench for fft_frame_src: directed scenarios, each task checks its own outputs.
module tb_fft_frame_src;

  localparam int NP = 256;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [2:0]  mode;
  logic [15:0] numFrames;
  logic [15:0] gapCycles;
  logic [15:0] amp;
  logic [15:0] step;
  logic        validOut;
  logic        sopOut;
  logic        eopOut;
  logic [15:0] xRe;
  logic [15:0] xIm;
  logic [15:0] frameIdx;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  fft_frame_src #(
    .N_POINTS (NP),
    .LOG2N    (8),
    .DW       (16),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .num_frames(numFrames),
    .gap_cycles(gapCycles),
    .amp       (amp),
    .step      (step),
    .valid_out (validOut),
    .sop_out   (sopOut),
    .eop_out   (eopOut),
    .x_re      (xRe),
    .x_im      (xIm),
    .frame_idx (frameIdx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the non-PRBS patterns, written directly from the formulas.
  function automatic logic [31:0] expSample(input logic [2:0] m, input logic [15:0] a,
                                            input logic [15:0] s, input int n);
    logic [15:0] nn;
    logic [15:0] re;
    logic [15:0] im;
    nn = 16'(n);
    re = 16'd0;
    im = 16'd0;
    case (m)
      3'd0: begin re = a - nn * s; im = re; end
      3'd1: begin re = a + nn * s; im = re; end
      3'd2: re = a;
      3'd3: re = (n == 0) ? a : 16'd0;
      3'd4: re = (n % 2 == 0) ? a : (16'd0 - a);
      default: begin re = 16'd0; im = 16'd0; end
    endcase
    return {re, im};
  endfunction

  function automatic logic [15:0] lfsrModel(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startRun(input logic [2:0] m, input logic [15:0] nf, input logic [15:0] gc,
                          input logic [15:0] a, input logic [15:0] s);
    mode      = m;
    numFrames = nf;
    gapCycles = gc;
    amp       = a;
    step      = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({validOut, sopOut, eopOut, xRe, xIm, frameIdx, busy, done} !== 53'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%h want=0",
               {validOut, sopOut, eopOut, xRe, xIm, frameIdx, busy, done});
    end
    rst = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    checks++;
    if ({validOut, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got=%b want=000", {validOut, busy, done});
    end
  endtask

  task automatic test_ramp_down();
    logic [34:0] want;
    startRun(3'd0, 16'd1, 16'd0, 16'd256, 16'd1);
    for (int n = 0; n < NP; n++) begin
      want = {1'b1, n == 0, n == NP - 1, expSample(3'd0, 16'd256, 16'd1, n)};
      checks++;
      if ({validOut, sopOut, eopOut, xRe, xIm} !== want) begin
        errors++;
        $display("[TB] FAIL ramp_dn_sample n=%0d got=%h want=%h", n,
                 {validOut, sopOut, eopOut, xRe, xIm}, want);
      end
      if (n == 0) begin
        checks++;
        if ({busy, frameIdx, xRe} !== {1'b1, 16'd0, 16'h0100}) begin
          errors++;
          $display("[TB] FAIL ramp_dn_first got=%h want=%h", {busy, frameIdx, xRe},
                   {1'b1, 16'd0, 16'h0100});
        end
      end
      tick();
    end
    checks++;
    if ({validOut, busy, done} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL ramp_dn_done got=%b want=001", {validOut, busy, done});
    end
    tick();
    checks++;
    if ({validOut, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL ramp_dn_idle got=%b want=000", {validOut, busy, done});
    end
  endtask

  task automatic test_gap();
    logic [34:0] want;
    startRun(3'd2, 16'd3, 16'd5, 16'd100, 16'd0);
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < NP; n++) begin
        want = {1'b1, n == 0, n == NP - 1, expSample(3'd2, 16'd100, 16'd0, n)};
        checks++;
        if ({validOut, sopOut, eopOut, xRe, xIm} !== want) begin
          errors++;
          $display("[TB] FAIL gap_sample f=%0d n=%0d got=%h want=%h", f, n,
                   {validOut, sopOut, eopOut, xRe, xIm}, want);
        end
        if (n == 0) begin
          checks++;
          if (frameIdx !== 16'(f)) begin
            errors++;
            $display("[TB] FAIL gap_frame_idx got=%0d want=%0d", frameIdx, f);
          end
        end
        // A start while busy, with new settings, must not disturb the run.
        if (f == 0 && n == 10) begin
          start = 1'b1;
          mode  = 3'd0;
          amp   = 16'd5;
        end
        tick();
        start = 1'b0;
      end
      if (f < 2) begin
        for (int g = 0; g < 5; g++) begin
          checks++;
          if ({validOut, sopOut, eopOut, xRe, xIm, busy, done} !== {35'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL gap_idle f=%0d g=%0d got=%h want=%h", f, g,
                     {validOut, sopOut, eopOut, xRe, xIm, busy, done}, {35'd0, 1'b1, 1'b0});
          end
          tick();
        end
      end
    end
    checks++;
    if ({validOut, busy, done} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL gap_done got=%b want=001", {validOut, busy, done});
    end
    tick();
  endtask

  task automatic test_stop();
    logic [34:0] want;
    stop = 1'b1;
    startRun(3'd0, 16'd0, 16'd0, 16'd1000, 16'd3);
    stop = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < NP; n++) begin
        want = {1'b1, n == 0, n == NP - 1, expSample(3'd0, 16'd1000, 16'd3, n)};
        checks++;
        if ({validOut, sopOut, eopOut, xRe, xIm} !== want) begin
          errors++;
          $display("[TB] FAIL stop_sample f=%0d n=%0d got=%h want=%h", f, n,
                   {validOut, sopOut, eopOut, xRe, xIm}, want);
        end
        if (n == 0) begin
          checks++;
          if (frameIdx !== 16'(f)) begin
            errors++;
            $display("[TB] FAIL stop_frame_idx got=%0d want=%0d", frameIdx, f);
          end
        end
        if (f == 2 && n == 10) stop = 1'b1;
        tick();
        stop = 1'b0;
      end
    end
    checks++;
    if ({validOut, sopOut, busy, done} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL stop_done got=%b want=0001", {validOut, sopOut, busy, done});
    end
    tick();
    tick();
    checks++;
    if ({validOut, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL stop_no_frame3 got=%b want=000", {validOut, busy, done});
    end
  endtask

  task automatic test_stop_in_gap();
    startRun(3'd2, 16'd0, 16'd4, 16'd7, 16'd0);
    for (int n = 0; n < NP; n++) tick();
    checks++;
    if ({validOut, busy, done} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL stopgap_in_gap got=%b want=010", {validOut, busy, done});
    end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({validOut, busy, done} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL stopgap_done got=%b want=001", {validOut, busy, done});
    end
    tick();
    checks++;
    if ({validOut, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL stopgap_idle got=%b want=000", {validOut, busy, done});
    end
  endtask

  task automatic test_wrap();
    logic [34:0] want;
    startRun(3'd1, 16'd1, 16'd0, 16'h7FFF, 16'd1);
    for (int n = 0; n < NP; n++) begin
      want = {1'b1, n == 0, n == NP - 1, expSample(3'd1, 16'h7FFF, 16'd1, n)};
      checks++;
      if ({validOut, sopOut, eopOut, xRe, xIm} !== want) begin
        errors++;
        $display("[TB] FAIL wrap_sample n=%0d got=%h want=%h", n,
                 {validOut, sopOut, eopOut, xRe, xIm}, want);
      end
      if (n == 1) begin
        checks++;
        if (xRe !== 16'h8000) begin
          errors++;
          $display("[TB] FAIL wrap_boundary got=%h want=8000", xRe);
        end
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_done got=%b want=1", done);
    end
    tick();
  endtask

  task automatic test_prbs();
    logic [15:0] model;
    logic [15:0] hand [3];
    hand[0] = 16'hACE1;
    hand[1] = 16'h5670;
    hand[2] = 16'hAB38;
    for (int r = 0; r < 2; r++) begin
      model = 16'hACE1;
      startRun(3'd5, 16'd1, 16'd0, 16'd0, 16'd0);
      for (int n = 0; n < NP; n++) begin
        if (n < 3) begin
          checks++;
          if ({xRe, xIm} !== {hand[n], ~hand[n]}) begin
            errors++;
            $display("[TB] FAIL prbs_hand r=%0d n=%0d got=%h want=%h", r, n, {xRe, xIm},
                     {hand[n], ~hand[n]});
          end
        end
        checks++;
        if ({validOut, sopOut, eopOut, xRe, xIm} !== {1'b1, n == 0, n == NP - 1, model, ~model}) begin
          errors++;
          $display("[TB] FAIL prbs_seq r=%0d n=%0d got=%h want=%h", r, n,
                   {validOut, sopOut, eopOut, xRe, xIm}, {1'b1, n == 0, n == NP - 1, model, ~model});
        end
        model = lfsrModel(model);
        tick();
      end
      tick();
    end
  endtask

  task automatic test_patterns();
    logic [2:0]  modes [3];
    logic [15:0] amps  [3];
    logic [34:0] want;
    modes[0] = 3'd4; amps[0] = 16'd50;
    modes[1] = 3'd3; amps[1] = 16'h1234;
    modes[2] = 3'd6; amps[2] = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      startRun(modes[k], 16'd1, 16'd0, amps[k], 16'd9);
      for (int n = 0; n < NP; n++) begin
        want = {1'b1, n == 0, n == NP - 1, expSample(modes[k], amps[k], 16'd9, n)};
        checks++;
        if ({validOut, sopOut, eopOut, xRe, xIm} !== want) begin
          errors++;
          $display("[TB] FAIL pattern m=%0d n=%0d got=%h want=%h", modes[k], n,
                   {validOut, sopOut, eopOut, xRe, xIm}, want);
        end
        if (k == 0 && n == 1) begin
          checks++;
          if (xRe !== 16'hFFCE) begin
            errors++;
            $display("[TB] FAIL nyquist_neg got=%h want=ffce", xRe);
          end
        end
        tick();
      end
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("[TB] FAIL pattern_done m=%0d got=%b want=1", modes[k], done);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    startRun(3'd1, 16'd0, 16'd0, 16'd0, 16'd2);
    for (int n = 0; n < 100; n++) tick();
    checks++;
    if ({validOut, sopOut, eopOut, xRe, xIm} !== {3'b100, 16'd200, 16'd200}) begin
      errors++;
      $display("[TB] FAIL rstmid_sample100 got=%h want=%h", {validOut, sopOut, eopOut, xRe, xIm},
               {3'b100, 16'd200, 16'd200});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({validOut, sopOut, eopOut, xRe, xIm, frameIdx, busy, done} !== 53'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs got=%h want=0",
               {validOut, sopOut, eopOut, xRe, xIm, frameIdx, busy, done});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({validOut, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rstmid_idle got=%b want=00", {validOut, busy});
    end
    startRun(3'd2, 16'd1, 16'd0, 16'd9, 16'd0);
    checks++;
    if ({validOut, sopOut, eopOut, xRe, xIm, frameIdx, busy} !== {3'b110, 16'd9, 16'd0, 16'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL rstmid_restart got=%h want=%h",
               {validOut, sopOut, eopOut, xRe, xIm, frameIdx, busy},
               {3'b110, 16'd9, 16'd0, 16'd0, 1'b1});
    end
    for (int n = 0; n < NP; n++) tick();
    checks++;
    if ({validOut, done} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rstmid_done got=%b want=01", {validOut, done});
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    mode      = 3'd0;
    numFrames = 16'd0;
    gapCycles = 16'd0;
    amp       = 16'd0;
    step      = 16'd0;
    test_reset();
    test_ramp_down();
    test_gap();
    test_stop();
    test_stop_in_gap();
    test_wrap();
    test_prbs();
    test_patterns();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
